// File: rtl/mc_ctrl_fsm_if.sv
// Instruction-decode interface between the memory/datapath side (master) and the
// multicycle sequencer (slave).
interface mc_ctrl_fsm_if;
   // Memory handshake: the sequencer holds mem_req (with mem_we/mem_sel stable)
   // from the first cycle of an access until the cycle in which mem_ready=1; the
   // transfer completes on that cycle's rising edge, and mem_ready is ignored
   // while mem_req=0.
   logic        start;
   logic        mem_ready;
   logic [11:0] instr_in;
   logic [3:0]  alu_flags;
   logic        dec_RegWrite;
   logic        dec_MemWrite;
   logic        dec_MemtoReg;
   logic [11:0] inst_q;
   logic [3:0]  flags_q;
   logic [2:0]  state;
   logic        mem_req;
   logic        mem_we;
   logic        mem_sel;
   logic        ir_we;
   logic        pc_we;
   logic        reg_we;
   logic        flag_we;
   logic        cond_pass;
   logic        err;

   modport master (
      output start, mem_ready, instr_in, alu_flags,
             dec_RegWrite, dec_MemWrite, dec_MemtoReg,
      input  inst_q, flags_q, state, mem_req, mem_we, mem_sel,
             ir_we, pc_we, reg_we, flag_we, cond_pass, err
   );

   modport slave (
      input  start, mem_ready, instr_in, alu_flags,
             dec_RegWrite, dec_MemWrite, dec_MemtoReg,
      output inst_q, flags_q, state, mem_req, mem_we, mem_sel,
             ir_we, pc_we, reg_we, flag_we, cond_pass, err
   );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multicycle control sequencer: fetches into the instruction register, holds NZCV,
// evaluates the condition field and gates decoder controls into write enables.
module mc_ctrl_fsm #(
   parameter int unsigned MAX_WAIT = 15
) (
   input logic          clk,
   input logic          rst_n,
   mc_ctrl_fsm_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_ERR    = 3'd7
   } state_e;

   localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

   state_e      state_q, state_d;
   logic [11:0] inst_q, inst_d;
   logic [3:0]  flags_q, flags_d;
   logic [7:0]  wait_q, wait_d;

   logic [3:0] cond;
   logic [1:0] op;
   logic       func5, func0;
   logic       flag_n, flag_z, flag_c, flag_v;
   logic       cond_pass;
   logic       in_wait_state, timeout;

   logic mem_req, mem_we, mem_sel;
   logic ir_we, pc_we, reg_we, flag_we;

   assign cond  = inst_q[11:8];
   assign op    = inst_q[7:6];
   assign func5 = inst_q[5];
   assign func0 = inst_q[0];
   assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

   always_comb begin
      cond_pass = 1'b0;
      case (cond)
         4'h0: cond_pass = flag_z;
         4'h1: cond_pass = !flag_z;
         4'h2: cond_pass = flag_c;
         4'h3: cond_pass = !flag_c;
         4'h4: cond_pass = flag_n;
         4'h5: cond_pass = !flag_n;
         4'h6: cond_pass = flag_v;
         4'h7: cond_pass = !flag_v;
         4'h8: cond_pass = flag_c && !flag_z;
         4'h9: cond_pass = !flag_c || flag_z;
         4'hA: cond_pass = (flag_n == flag_v);
         4'hB: cond_pass = (flag_n != flag_v);
         4'hC: cond_pass = !flag_z && (flag_n == flag_v);
         4'hD: cond_pass = flag_z || (flag_n != flag_v);
         4'hE: cond_pass = 1'b1;
         default: cond_pass = 1'b0;
      endcase
   end

   // Enables are decoded from the current state; FETCH and EXEC/MEM/WB also look
   // at the live inputs, so these are Mealy outputs.
   always_comb begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
      mem_sel = 1'b0;
      ir_we   = 1'b0;
      pc_we   = 1'b0;
      reg_we  = 1'b0;
      flag_we = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_req = 1'b1;
            if (bus.mem_ready) begin
               ir_we = 1'b1;
               pc_we = 1'b1;
            end
         end
         S_EXEC: begin
            if (op == 2'b00) begin
               reg_we  = bus.dec_RegWrite;
               flag_we = func5;
            end
         end
         S_MEM: begin
            mem_req = 1'b1;
            mem_sel = 1'b1;
            mem_we  = bus.dec_MemWrite;
         end
         S_WB: begin
            reg_we = bus.dec_RegWrite & bus.dec_MemtoReg;
         end
         default: ;
      endcase
   end

   assign in_wait_state = (state_q == S_FETCH) || (state_q == S_MEM);
   assign timeout       = in_wait_state && !bus.mem_ready && (wait_q == WAIT_LAST);

   always_comb begin
      state_d = state_q;
      inst_d  = ir_we   ? bus.instr_in  : inst_q;
      flags_d = flag_we ? bus.alu_flags : flags_q;
      // Any transition (including into FETCH/MEM) restarts the wait count.
      wait_d  = 8'd0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) state_d = S_FETCH;
         end
         S_FETCH: begin
            if (bus.mem_ready)  state_d = S_DECODE;
            else if (timeout)   state_d = S_ERR;
            else                wait_d  = wait_q + 8'd1;
         end
         S_DECODE: begin
            if (!cond_pass || op[1]) state_d = S_FETCH;
            else                     state_d = S_EXEC;
         end
         S_EXEC: begin
            if (op == 2'b01) state_d = S_MEM;
            else             state_d = S_FETCH;
         end
         S_MEM: begin
            if (bus.mem_ready) state_d = func0 ? S_WB : S_FETCH;
            else if (timeout)  state_d = S_ERR;
            else               wait_d  = wait_q + 8'd1;
         end
         S_WB: begin
            state_d = S_FETCH;
         end
         S_ERR: begin
            state_d = S_ERR;
         end
         default: begin
            state_d = S_ERR;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         inst_q  <= 12'h000;
         flags_q <= 4'h0;
         wait_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         inst_q  <= inst_d;
         flags_q <= flags_d;
         wait_q  <= wait_d;
      end
   end

   assign bus.inst_q    = inst_q;
   assign bus.flags_q   = flags_q;
   assign bus.state     = state_q;
   assign bus.mem_req   = mem_req;
   assign bus.mem_we    = mem_we;
   assign bus.mem_sel   = mem_sel;
   assign bus.ir_we     = ir_we;
   assign bus.pc_we     = pc_we;
   assign bus.reg_we    = reg_we;
   assign bus.flag_we   = flag_we;
   assign bus.cond_pass = cond_pass;
   assign bus.err       = (state_q == S_ERR);

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: fetch/decode/execute paths, loads, stores,
// condition codes, watchdog error and asynchronous reset.
module tb_mc_ctrl_fsm;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   mc_ctrl_fsm_if bus ();

   mc_ctrl_fsm #(.MAX_WAIT(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n            = 1'b0;
      bus.start        = 1'b0;
      bus.mem_ready    = 1'b0;
      bus.instr_in     = 12'h000;
      bus.alu_flags    = 4'h0;
      bus.dec_RegWrite = 1'b0;
      bus.dec_MemWrite = 1'b0;
      bus.dec_MemtoReg = 1'b0;
      #2;
      chk("rst_state", bus.state, 12'd0);
      chk("rst_inst", bus.inst_q, 12'h000);
      chk("rst_flags", bus.flags_q, 12'h0);
      chk("rst_mem_req", bus.mem_req, 12'd0);
      chk("rst_err", bus.err, 12'd0);
      chk("rst_cond_eq_z0", bus.cond_pass, 12'd0);
      #10 rst_n = 1'b1;
      step();
      chk("idle_state", bus.state, 12'd0);

      // Data-processing AL instruction with flag update
      bus.start = 1'b1; bus.mem_ready = 1'b1; bus.instr_in = 12'hE22;
      bus.dec_RegWrite = 1'b1; bus.alu_flags = 4'b0100;
      #1;
      step(); bus.start = 1'b0; #1;
      chk("t1_fetch_state", bus.state, 12'd1);
      chk("t1_fetch_req", bus.mem_req, 12'd1);
      chk("t1_fetch_sel", bus.mem_sel, 12'd0);
      chk("t1_fetch_ir_we", bus.ir_we, 12'd1);
      chk("t1_fetch_pc_we", bus.pc_we, 12'd1);
      step();
      chk("t1_dec_state", bus.state, 12'd2);
      chk("t1_dec_inst", bus.inst_q, 12'hE22);
      chk("t1_dec_cond", bus.cond_pass, 12'd1);
      chk("t1_dec_reg_we", bus.reg_we, 12'd0);
      chk("t1_dec_req", bus.mem_req, 12'd0);
      step();
      chk("t1_exec_state", bus.state, 12'd3);
      chk("t1_exec_reg_we", bus.reg_we, 12'd1);
      chk("t1_exec_flag_we", bus.flag_we, 12'd1);
      chk("t1_exec_flags_hold", bus.flags_q, 12'h0);
      step();
      chk("t1_back_fetch", bus.state, 12'd1);
      chk("t1_flags", bus.flags_q, 12'h4);

      // Clear flags, then EQ with Z=0 fails
      bus.alu_flags = 4'b0000; #1;
      step(); step(); step();
      chk("t2_pre_flags", bus.flags_q, 12'h0);
      chk("t2_pre_state", bus.state, 12'd1);
      bus.instr_in = 12'h022; #1;
      step();
      chk("t2_dec_state", bus.state, 12'd2);
      chk("t2_dec_inst", bus.inst_q, 12'h022);
      chk("t2_dec_cond", bus.cond_pass, 12'd0);
      chk("t2_dec_reg_we", bus.reg_we, 12'd0);
      chk("t2_dec_flag_we", bus.flag_we, 12'd0);
      step();
      chk("t2_skip_fetch", bus.state, 12'd1);
      chk("t2_fetch_reg_we", bus.reg_we, 12'd0);

      // GE passes with N=V=0, then loads N=1 and GE fails
      bus.instr_in = 12'hA22; bus.alu_flags = 4'b1000; #1;
      step();
      chk("ge_pass_cond", bus.cond_pass, 12'd1);
      step();
      chk("ge_pass_exec", bus.state, 12'd3);
      step();
      chk("ge_flags", bus.flags_q, 12'h8);
      step();
      chk("ge_fail_cond", bus.cond_pass, 12'd0);
      chk("ge_fail_dec", bus.state, 12'd2);
      step();
      chk("ge_fail_fetch", bus.state, 12'd1);

      // Load with three wait cycles in MEM
      bus.instr_in = 12'hE41; bus.dec_RegWrite = 1'b1; bus.dec_MemtoReg = 1'b1;
      bus.alu_flags = 4'b1111; #1;
      step();
      chk("t3_dec_cond", bus.cond_pass, 12'd1);
      step();
      chk("t3_exec_state", bus.state, 12'd3);
      chk("t3_exec_reg_we", bus.reg_we, 12'd0);
      chk("t3_exec_flag_we", bus.flag_we, 12'd0);
      chk("t3_exec_req", bus.mem_req, 12'd0);
      bus.mem_ready = 1'b0; #1;
      step();
      for (int i = 0; i < 3; i++) begin
         chk("t3_mem_wait_state", bus.state, 12'd4);
         chk("t3_mem_wait_req", bus.mem_req, 12'd1);
         chk("t3_mem_wait_sel", bus.mem_sel, 12'd1);
         chk("t3_mem_wait_we", bus.mem_we, 12'd0);
         step();
      end
      bus.mem_ready = 1'b1; #1;
      chk("t3_mem_ready_state", bus.state, 12'd4);
      chk("t3_mem_ready_req", bus.mem_req, 12'd1);
      step();
      chk("t3_wb_state", bus.state, 12'd5);
      chk("t3_wb_reg_we", bus.reg_we, 12'd1);
      chk("t3_wb_req", bus.mem_req, 12'd0);
      chk("t3_wb_flags", bus.flags_q, 12'h8);
      step();
      chk("t3_after_wb", bus.state, 12'd1);
      chk("t3_after_wb_reg_we", bus.reg_we, 12'd0);

      // Store
      bus.instr_in = 12'hE40; bus.dec_MemWrite = 1'b1; #1;
      step();
      step();
      chk("t4_exec_reg_we", bus.reg_we, 12'd0);
      step();
      chk("t4_mem_state", bus.state, 12'd4);
      chk("t4_mem_we", bus.mem_we, 12'd1);
      chk("t4_mem_sel", bus.mem_sel, 12'd1);
      chk("t4_mem_reg_we", bus.reg_we, 12'd0);
      step();
      chk("t4_back_fetch", bus.state, 12'd1);
      chk("t4_fetch_we", bus.mem_we, 12'd0);
      chk("t4_fetch_reg_we", bus.reg_we, 12'd0);

      // Watchdog: four FETCH cycles without ready, then ERR
      bus.mem_ready = 1'b0; bus.dec_MemWrite = 1'b0; #1;
      chk("t5_fetch_req", bus.mem_req, 12'd1);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t5_fetch_wait", bus.state, 12'd1);
      end
      step();
      chk("t5_err_state", bus.state, 12'd7);
      chk("t5_err_flag", bus.err, 12'd1);
      chk("t5_err_req", bus.mem_req, 12'd0);
      bus.start = 1'b1; bus.mem_ready = 1'b1; #1;
      step(); step();
      chk("t5_err_stuck", bus.state, 12'd7);
      chk("t5_err_sticky", bus.err, 12'd1);
      chk("t5_err_ir_we", bus.ir_we, 12'd0);
      bus.start = 1'b0;
      rst_n = 1'b0; #1;
      chk("t5_rst_state", bus.state, 12'd0);
      chk("t5_rst_err", bus.err, 12'd0);
      step();
      rst_n = 1'b1;

      // Asynchronous reset in the middle of MEM
      bus.start = 1'b1; bus.instr_in = 12'hE22; bus.alu_flags = 4'b1111; #1;
      step(); bus.start = 1'b0; #1;
      step(); step(); step();
      chk("t6_flags", bus.flags_q, 12'hF);
      bus.instr_in = 12'hE41; #1;
      step(); step();
      bus.mem_ready = 1'b0; #1;
      step();
      chk("t6_mem_state", bus.state, 12'd4);
      chk("t6_mem_req", bus.mem_req, 12'd1);
      #3 rst_n = 1'b0;
      #1;
      chk("t6_async_state", bus.state, 12'd0);
      chk("t6_async_req", bus.mem_req, 12'd0);
      chk("t6_async_sel", bus.mem_sel, 12'd0);
      chk("t6_async_inst", bus.inst_q, 12'h000);
      chk("t6_async_flags", bus.flags_q, 12'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Multicycle sequencer at the consuming end of the instruction-decode interface. It fetches 12-bit instruction words over a ready handshake and holds them in the instruction register that drives the main decoder. It also holds the NZCV flag register, evaluates the condition field, and gates the decoder's static controls into per-cycle write enables. It sits between the memory port and the datapath in the multicycle processor.

## Interface
- MAX_WAIT, 15: consecutive cycles with mem_ready low in a wait state before the block enters ERR. Legal range 1..255.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  leave IDLE; ignored in all other states
- mem_ready  in  1  memory access complete; sampled only in FETCH and MEM
- instr_in  in  12  fetched word {cond[11:8], op[7:6], func[5:0]}
- alu_flags  in  4  {N,Z,C,V} from the ALU
- dec_RegWrite, dec_MemWrite, dec_MemtoReg  in  1 each  static controls from the decoder
- inst_q  out  12  instruction register; drives the decoder
- flags_q  out  4  flag register {N,Z,C,V}; drives the decoder flag inputs
- state  out  3  IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, ERR=7
- mem_req, mem_we, mem_sel  out  1 each  memory request, write, address select (0=PC, 1=ALU result)
- ir_we, pc_we, reg_we, flag_we  out  1 each  write enables
- cond_pass  out  1  condition result for inst_q[11:8] against flags_q
- err  out  1  sticky watchdog error

## Operation
- Reset (asynchronous, any state) clears:
  - state to IDLE;
  - inst_q and flags_q to 0;
  - the wait counter to 0;
  - every output to 0.
- The condition test is combinational on inst_q and flags_q:
  - 0 EQ: Z; 1 NE: !Z
  - 2 CS: C; 3 CC: !C
  - 4 MI: N; 5 PL: !N
  - 6 VS: V; 7 VC: !V
  - 8 HI: C&!Z; 9 LS: !C|Z
  - A GE: N==V; B LT: N!=V
  - C GT: !Z&(N==V); D LE: Z|(N!=V)
  - E AL: 1; F: 0
- State behaviour:
  - IDLE: all enables 0. start=1 moves to FETCH.
  - FETCH: mem_req=1, mem_sel=0. When mem_ready=1, ir_we=1 and pc_we=1 in the same cycle (Mealy). inst_q takes instr_in at that edge, then DECODE.
  - DECODE: lasts one cycle, no enables. If cond_pass=0, or op[1]=1 (reserved, executed as a NOP), go to FETCH. Otherwise go to EXEC.
  - EXEC, op=00: reg_we=dec_RegWrite and flag_we=func[5]. When flag_we=1, flags_q takes alu_flags at the edge. Then FETCH.
  - EXEC, op=01: no enables, then MEM.
  - MEM: mem_req=1, mem_sel=1, mem_we=dec_MemWrite. On mem_ready=1, a store (func[0]=0) goes to FETCH and a load (func[0]=1) goes to WB.
  - WB: reg_we=dec_RegWrite&dec_MemtoReg for one cycle, then FETCH.
  - ERR: all enables 0, err=1. Only rst_n exits ERR.
- Watchdog:
  - The wait counter clears on entry to FETCH or MEM.
  - It increments on each cycle in those states with mem_ready=0.
  - When mem_ready=0 and the count equals MAX_WAIT-1, the next state is ERR.
  - mem_ready=1 in the same cycle always wins over the watchdog.
- Once started, the block runs continuously; there is no stop input.

## Timing
- Cycles per instruction with zero-wait memory:
  - data-processing: 3 (FETCH, DECODE, EXEC);
  - store: 4;
  - load: 5;
  - failed condition or reserved op: 2.
- Each memory wait cycle adds 1.
- mem_req stays high from the first cycle of FETCH or MEM through the cycle in which mem_ready=1. It drops in the following cycle.
- inst_q and flags_q change only on the edge that ends FETCH (with ready) or EXEC (with flag_we), respectively.
- cond_pass is valid in every state. It is consumed only in DECODE.

## Test plan
1. Reset, then start=1 with mem_ready held at 1, instr_in=0xE22, dec_RegWrite=1, alu_flags=0100 → state 1,2,3,1. In EXEC, reg_we=1 and flag_we=1. After EXEC, flags_q=0100.
2. With flags_q=0000, fetch 0x022 (EQ) → state 1,2,1. reg_we and flag_we stay 0 throughout.
3. Load 0xE41 with dec_RegWrite=dec_MemtoReg=1, mem_ready low for 3 cycles in MEM → mem_req=1 and mem_sel=1 for 4 cycles, mem_we=0, then WB with reg_we=1 for exactly one cycle, then FETCH.
4. Store 0xE40 with dec_MemWrite=1 → mem_we=1 throughout MEM, return to FETCH, reg_we never asserted.
5. MAX_WAIT=4, mem_ready held at 0 in FETCH → ERR (state=7) after 4 FETCH cycles. err=1, mem_req=0. start and mem_ready are then ignored; err clears only on rst_n.
6. Assert rst_n=0 asynchronously in mid-MEM → state=0, mem_req=0, inst_q=0x000 and flags_q=0 immediately, before the next clock edge.
